// File: rtl/pi_digit_sequencer_if.sv
// Control and display-position bundle for pi_digit_sequencer.
// master: the side that drives run/step/rate and consumes the position.
// slave:  the sequencer itself.
interface pi_digit_sequencer_if #(
  parameter int RATE_W = 3
);
  logic              run;
  logic              step;
  logic [RATE_W-1:0] rate;
  logic [9:0]        group;
  logic [1:0]        sel;
  logic              dot;
  logic              blank;
  logic              wrap;

  modport master (
    output run, step, rate,
    input  group, sel, dot, blank, wrap
  );

  modport slave (
    input  run, step, rate,
    output group, sel, dot, blank, wrap
  );
endinterface

// File: rtl/pi_digit_sequencer.sv
// pi_digit_sequencer: paced position generator for the pi digit display.
// Walks (group, sel) through the densely packed triple table, inserting the
// decimal point once after the leading "3", with run/step control and a
// dwell of 2^rate cycles per item.
// Optional build macro PI_SEQ_BLANK_EN: adds a GAP state so every automatic
// advance is followed by one dwell period with blank=1. Without it, blank is
// tied low and items follow each other back to back.
module pi_digit_sequencer #(
  parameter int LAST_GROUP = 483,
  parameter int RATE_W     = 3
) (
  input logic                  clk,
  input logic                  reset,
  pi_digit_sequencer_if.slave  bus
);

  // Counter wide enough for the longest dwell (2^(2^RATE_W - 1) cycles).
  localparam int CNT_W = (1 << RATE_W) - 1;

`ifdef PI_SEQ_BLANK_EN
  typedef enum logic {SHOW = 1'b0, GAP = 1'b1} state_t;
`else
  typedef enum logic {SHOW = 1'b0} state_t;
`endif

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [9:0]       group_reg, group_next;
  logic [1:0]       sel_reg, sel_next;
  logic             dot_reg, dot_next;
  logic             dot_done_reg, dot_done_next;
  logic             wrap_reg, wrap_next;
  logic             step_q_reg;

  logic [CNT_W-1:0] limit;
  logic             expire;
  logic             step_edge;
  logic             advance;

  // ">=" rather than "==" so that lowering rate mid-dwell expires at once
  // instead of letting the counter run past the new limit and wrap.
  assign limit     = CNT_W'((32'd1 << bus.rate) - 32'd1);
  assign expire    = (cnt_reg >= limit);
  assign step_edge = bus.step & ~step_q_reg;

  // Next-state, dwell counter and position-advance logic.
  always_comb begin
    state_next    = state_reg;
    cnt_next      = cnt_reg;
    group_next    = group_reg;
    sel_next      = sel_reg;
    dot_next      = dot_reg;
    dot_done_next = dot_done_reg;
    wrap_next     = 1'b0;
    advance       = 1'b0;

    case (state_reg)
      SHOW: begin
        if (bus.run) begin
          if (expire) begin
            cnt_next = '0;
            advance  = 1'b1;
`ifdef PI_SEQ_BLANK_EN
            state_next = GAP;
`endif
          end else begin
            cnt_next = cnt_reg + CNT_W'(1);
          end
        end else begin
          // Step mode: counter parked at zero, manual edges advance directly.
          cnt_next = '0;
          advance  = step_edge;
        end
      end
`ifdef PI_SEQ_BLANK_EN
      GAP: begin
        if (bus.run) begin
          if (expire) begin
            cnt_next   = '0;
            state_next = SHOW;
          end else begin
            cnt_next = cnt_reg + CNT_W'(1);
          end
        end else begin
          // Leaving run mid-gap: show the already-advanced item right away.
          cnt_next   = '0;
          state_next = SHOW;
        end
      end
`endif
      default: begin
        state_next = SHOW;
        cnt_next   = '0;
      end
    endcase

    if (advance) begin
      if (dot_reg) begin
        dot_next      = 1'b0;
        sel_next      = 2'd1;
        dot_done_next = 1'b1;
      end else if (group_reg == 10'd0 && sel_reg == 2'd0 && !dot_done_reg) begin
        dot_next = 1'b1;
      end else if (sel_reg == 2'd2) begin
        sel_next = 2'd0;
        if (group_reg == 10'(LAST_GROUP)) begin
          group_next    = 10'd0;
          wrap_next     = 1'b1;
          dot_done_next = 1'b0;
        end else begin
          group_next = group_reg + 10'd1;
        end
      end else begin
        sel_next = sel_reg + 2'd1;
      end
    end
  end

  // State, counter and registered outputs; reset abandons any dwell or gap.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg    <= SHOW;
      cnt_reg      <= '0;
      group_reg    <= 10'd0;
      sel_reg      <= 2'd0;
      dot_reg      <= 1'b0;
      dot_done_reg <= 1'b0;
      wrap_reg     <= 1'b0;
      step_q_reg   <= 1'b0;
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      group_reg    <= group_next;
      sel_reg      <= sel_next;
      dot_reg      <= dot_next;
      dot_done_reg <= dot_done_next;
      wrap_reg     <= wrap_next;
      step_q_reg   <= bus.step;
    end
  end

  assign bus.group = group_reg;
  assign bus.sel   = sel_reg;
  assign bus.dot   = dot_reg;
  assign bus.wrap  = wrap_reg;

`ifdef PI_SEQ_BLANK_EN
  logic blank_reg;

  // Blank follows the GAP state, registered alongside the position.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      blank_reg <= 1'b0;
    end else begin
      blank_reg <= (state_next == GAP);
    end
  end

  assign bus.blank = blank_reg;
`else
  assign bus.blank = 1'b0;
`endif

endmodule

// File: tb/tb_pi_digit_sequencer.sv
// Directed testbench for pi_digit_sequencer (default parameters).
module tb_pi_digit_sequencer;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  pi_digit_sequencer_if #(.RATE_W(3)) bus ();

  pi_digit_sequencer #(
    .LAST_GROUP(483),
    .RATE_W    (3)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance one clock and settle away from the active edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic run_v, input logic [2:0] rate_v);
    reset    = 1'b1;
    bus.run  = run_v;
    bus.step = 1'b0;
    bus.rate = rate_v;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset    = 1'b1;
    bus.run  = 1'b0;
    bus.step = 1'b0;
    bus.rate = 3'd0;
    #1;
    checks++;
    if ({bus.dot, bus.group, bus.sel} !== 13'd0) begin
      failures++;
      $display("FAIL reset_pos got=%h exp=%h", {bus.dot, bus.group, bus.sel}, 13'd0);
    end
    checks++;
    if ({bus.blank, bus.wrap} !== 2'b00) begin
      failures++;
      $display("FAIL reset_flags got=%b exp=00", {bus.blank, bus.wrap});
    end
    tick();
    reset = 1'b0;
    $display("test_reset done");
  endtask

`ifndef PI_SEQ_BLANK_EN
  task automatic test_auto_sequence();
    logic [12:0] exp_pos [5];
    int wraps;
    exp_pos[0] = {1'b0, 10'd0, 2'd0};
    exp_pos[1] = {1'b1, 10'd0, 2'd0};
    exp_pos[2] = {1'b0, 10'd0, 2'd1};
    exp_pos[3] = {1'b0, 10'd0, 2'd2};
    exp_pos[4] = {1'b0, 10'd1, 2'd0};
    do_reset(1'b1, 3'd0);
    for (int t = 0; t < 5; t++) begin
      if (t > 0) tick();
      checks++;
      if ({bus.dot, bus.group, bus.sel} !== exp_pos[t] || bus.blank !== 1'b0) begin
        failures++;
        $display("FAIL auto_item%0d got=%h blank=%b exp=%h blank=0", t,
                 {bus.dot, bus.group, bus.sel}, bus.blank, exp_pos[t]);
      end
    end
    wraps = 0;
    for (int t = 5; t <= 1452; t++) begin
      tick();
      if (bus.wrap) wraps++;
    end
    checks++;
    if ({bus.dot, bus.group, bus.sel} !== {1'b0, 10'd483, 2'd2} || wraps != 0) begin
      failures++;
      $display("FAIL auto_last got=%h wraps=%0d exp=%h wraps=0",
               {bus.dot, bus.group, bus.sel}, wraps, {1'b0, 10'd483, 2'd2});
    end
    tick();
    checks++;
    if ({bus.dot, bus.group, bus.sel} !== 13'd0 || bus.wrap !== 1'b1) begin
      failures++;
      $display("FAIL auto_wrap got=%h wrap=%b exp=%h wrap=1",
               {bus.dot, bus.group, bus.sel}, bus.wrap, 13'd0);
    end
    tick();
    checks++;
    if (bus.dot !== 1'b1 || bus.wrap !== 1'b0) begin
      failures++;
      $display("FAIL auto_dot_again got dot=%b wrap=%b exp dot=1 wrap=0", bus.dot, bus.wrap);
    end
    $display("test_auto_sequence done");
  endtask

  task automatic test_rate_change();
    do_reset(1'b1, 3'd7);
    repeat (100) tick();
    checks++;
    if ({bus.dot, bus.group, bus.sel} !== 13'd0) begin
      failures++;
      $display("FAIL rate_hold100 got=%h exp=%h", {bus.dot, bus.group, bus.sel}, 13'd0);
    end
    bus.rate = 3'd3;
    tick();
    checks++;
    if (bus.dot !== 1'b1) begin
      failures++;
      $display("FAIL rate_drop_expire got dot=%b exp dot=1", bus.dot);
    end
    repeat (7) tick();
    checks++;
    if (bus.dot !== 1'b1) begin
      failures++;
      $display("FAIL rate_dwell8_hold got dot=%b exp dot=1", bus.dot);
    end
    tick();
    checks++;
    if ({bus.dot, bus.group, bus.sel} !== {1'b0, 10'd0, 2'd1}) begin
      failures++;
      $display("FAIL rate_dwell8_adv got=%h exp=%h", {bus.dot, bus.group, bus.sel},
               {1'b0, 10'd0, 2'd1});
    end
    repeat (8) tick();
    checks++;
    if ({bus.dot, bus.group, bus.sel} !== {1'b0, 10'd0, 2'd2}) begin
      failures++;
      $display("FAIL rate_dwell8_adv2 got=%h exp=%h", {bus.dot, bus.group, bus.sel},
               {1'b0, 10'd0, 2'd2});
    end
    $display("test_rate_change done");
  endtask
`else
  task automatic test_blanking();
    logic [12:0] exp_pos [3];
    int idx;
    logic exp_blank;
    exp_pos[0] = {1'b0, 10'd0, 2'd0};
    exp_pos[1] = {1'b1, 10'd0, 2'd0};
    exp_pos[2] = {1'b0, 10'd0, 2'd1};
    do_reset(1'b1, 3'd2);
    for (int t = 0; t <= 13; t++) begin
      if (t > 0) tick();
      idx       = (t + 4) / 8;
      exp_blank = ((t / 4) % 2) == 1;
      checks++;
      if ({bus.dot, bus.group, bus.sel} !== exp_pos[idx] || bus.blank !== exp_blank) begin
        failures++;
        $display("FAIL blank_t%0d got=%h blank=%b exp=%h blank=%b", t,
                 {bus.dot, bus.group, bus.sel}, bus.blank, exp_pos[idx], exp_blank);
      end
    end
    bus.run = 1'b0;
    for (int t = 0; t < 5; t++) begin
      tick();
      checks++;
      if ({bus.dot, bus.group, bus.sel} !== exp_pos[2] || bus.blank !== 1'b0) begin
        failures++;
        $display("FAIL gap_run_drop%0d got=%h blank=%b exp=%h blank=0", t,
                 {bus.dot, bus.group, bus.sel}, bus.blank, exp_pos[2]);
      end
    end
    $display("test_blanking done");
  endtask
`endif

  task automatic test_step();
    logic [12:0] exp_pos [3];
    logic [12:0] prev;
    int changes;
    exp_pos[0] = {1'b1, 10'd0, 2'd0};
    exp_pos[1] = {1'b0, 10'd0, 2'd1};
    exp_pos[2] = {1'b0, 10'd0, 2'd2};
    do_reset(1'b0, 3'd0);
    repeat (3) tick();
    checks++;
    if ({bus.dot, bus.group, bus.sel} !== 13'd0 || bus.blank !== 1'b0) begin
      failures++;
      $display("FAIL step_idle got=%h blank=%b exp=%h blank=0",
               {bus.dot, bus.group, bus.sel}, bus.blank, 13'd0);
    end
    for (int p = 0; p < 3; p++) begin
      prev    = {bus.dot, bus.group, bus.sel};
      changes = 0;
      bus.step = 1'b1;
      for (int c = 0; c < 8; c++) begin
        if (c == 5) bus.step = 1'b0;
        tick();
        if ({bus.dot, bus.group, bus.sel} !== prev) changes++;
        prev = {bus.dot, bus.group, bus.sel};
      end
      checks++;
      if (prev !== exp_pos[p] || changes != 1 || bus.blank !== 1'b0) begin
        failures++;
        $display("FAIL step_pulse%0d got=%h changes=%0d exp=%h changes=1", p, prev,
                 changes, exp_pos[p]);
      end
    end
    $display("test_step done");
  endtask

  task automatic test_async_reset();
    int mult;
    int wraps;
`ifdef PI_SEQ_BLANK_EN
    mult = 2;
`else
    mult = 1;
`endif
    do_reset(1'b1, 3'd0);
    repeat (601 * mult) tick();
    checks++;
    if ({bus.dot, bus.group, bus.sel} !== {1'b0, 10'd200, 2'd0}) begin
      failures++;
      $display("FAIL areset_reach got=%h exp=%h", {bus.dot, bus.group, bus.sel},
               {1'b0, 10'd200, 2'd0});
    end
    bus.rate = 3'd3;
    repeat (3) tick();
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if ({bus.dot, bus.group, bus.sel, bus.blank, bus.wrap} !== 15'd0) begin
      failures++;
      $display("FAIL areset_immediate got=%h exp=%h",
               {bus.dot, bus.group, bus.sel, bus.blank, bus.wrap}, 15'd0);
    end
    wraps = 0;
    for (int c = 0; c < 3; c++) begin
      tick();
      if (bus.wrap !== 1'b0) wraps++;
    end
    reset = 1'b0;
    for (int t = 0; t < 8; t++) begin
      if (t > 0) tick();
      if (bus.wrap !== 1'b0) wraps++;
      checks++;
      if ({bus.dot, bus.group, bus.sel} !== 13'd0) begin
        failures++;
        $display("FAIL areset_dwell_t%0d got=%h exp=%h", t, {bus.dot, bus.group, bus.sel}, 13'd0);
      end
    end
    tick();
    checks++;
    if (bus.dot !== 1'b1 || wraps != 0) begin
      failures++;
      $display("FAIL areset_first_adv got dot=%b wraps=%0d exp dot=1 wraps=0", bus.dot, wraps);
    end
    $display("test_async_reset done");
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
`ifndef PI_SEQ_BLANK_EN
    test_auto_sequence();
    test_rate_change();
`else
    test_blanking();
`endif
    test_step();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
